// File: rtl/aes_ctr_stream.sv
// ==== aes_ctr_stream : AES counter-mode stream unit over a combinational AESEngine, rev 1.0 ====
`default_nettype none

module AESEngine #(
    parameter int KEY_LEN = 128,
    parameter int ROUNDS  = 10,
    parameter int NK      = 4
) (
    input  logic [KEY_LEN-1:0] key_i,
    input  logic [127:0]       data_i,
    output logic [127:0]       data_o
);
    localparam int NW = 4 * (ROUNDS + 1);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as x^254 (field inverse, 0 -> 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (i != 0) r = gmul(r, x);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] encrypt(input logic [KEY_LEN-1:0] key, input logic [127:0] pt);
        logic [31:0]        w [NW];
        logic [KEY_LEN-1:0] kk;
        logic [31:0]        t;
        logic [7:0]         rc;
        logic [127:0]       s;
        logic [127:0]       sr;
        logic [7:0]         a0, a1, a2, a3;
        kk = key;
        for (int i = 0; i < NK; i++) begin
            w[i] = kk[KEY_LEN-1 -: 32];
            kk   = kk << 32;
        end
        rc = 8'h01;
        for (int i = NK; i < NW; i++) begin
            t = w[i-1];
            if (i % NK == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end else if (NK > 6 && i % NK == 4) begin
                t = subword(t);
            end
            w[i] = w[i-NK] ^ t;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= ROUNDS; r++) begin
            // Byte n sits at row n%4, column n/4; SubBytes and ShiftRows fused.
            for (int n = 0; n < 16; n++) begin
                sr[127-8*n -: 8] = sbox(s[127-8*((n % 4) + 4*(((n / 4) + (n % 4)) % 4)) -: 8]);
            end
            if (r != ROUNDS) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = sr[127-32*c -: 8];
                    a1 = sr[119-32*c -: 8];
                    a2 = sr[111-32*c -: 8];
                    a3 = sr[103-32*c -: 8];
                    sr[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                          a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                          a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                          xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
                end
            end
            s = sr ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return s;
    endfunction

    assign data_o = encrypt(key_i, data_i);
endmodule

module aes_ctr_stream #(
    parameter int KEY_LEN = 128,
    parameter int ROUNDS  = 10,
    parameter int NK      = 4,
    parameter int CTR_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic [KEY_LEN-1:0] cfg_key,
    input  logic [127:0]       cfg_iv,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_data,
    input  logic [15:0]        in_keep,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_data,
    output logic [15:0]        out_keep,
    output logic               out_last,
    output logic               keyed,
    output logic               wrap_err
);
    localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t             state_q;
    logic [KEY_LEN-1:0] key_q;
    logic [127:0]       ctr_q, ctr_d;
    logic [127:0]       out_data_q, out_data_d;
    logic [15:0]        out_keep_q;
    logic               out_last_q, out_valid_q, keyed_q, wrap_err_q;
    logic [127:0]       keystream, keep_mask;
    logic               accept, ctr_at_max;

    AESEngine #(
        .KEY_LEN (KEY_LEN),
        .ROUNDS  (ROUNDS),
        .NK      (NK)
    ) u_engine (
        .key_i  (key_q),
        .data_i (ctr_q),
        .data_o (keystream)
    );

    always_comb begin
        keep_mask = '0;
        for (int i = 0; i < 16; i++) keep_mask[8*i +: 8] = {8{in_keep[i]}};
    end

    assign in_ready   = (state_q == S_RUN) && !cfg_load && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign out_data_d = (in_data ^ keystream) & keep_mask;
    // Only the low field counts; the nonce above it is held as-is.
    assign ctr_d      = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);
    assign ctr_at_max = ((ctr_q & CTR_MASK) == CTR_MASK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            ctr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            keyed_q     <= 1'b0;
            wrap_err_q  <= 1'b0;
        end else if (cfg_load) begin
            state_q     <= S_RUN;
            key_q       <= cfg_key;
            ctr_q       <= cfg_iv;
            out_valid_q <= 1'b0;
            keyed_q     <= 1'b1;
            wrap_err_q  <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= out_data_d;
            out_keep_q  <= in_keep;
            out_last_q  <= in_last;
            ctr_q       <= ctr_d;
            if (ctr_at_max) begin
                state_q    <= S_HALT;
                wrap_err_q <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign keyed     = keyed_q;
    assign wrap_err  = wrap_err_q;
endmodule

`default_nettype wire

// File: tb/tb_aes_ctr_stream.sv
// ==== tb_aes_ctr_stream : known-answer table, scoreboard streaming and corner sequences, rev 1.0 ====
`default_nettype none

module tb_aes_ctr_stream;
    logic         clk = 1'b0;
    logic         rst_n, cfg_load, in_valid, in_last, out_ready;
    logic [127:0] cfg_key, cfg_iv, in_data;
    logic [191:0] key192;
    logic [255:0] key256;
    logic [15:0]  in_keep;
    logic         in_ready, out_valid, out_last, keyed, wrap_err;
    logic [127:0] out_data;
    logic [15:0]  out_keep;
    logic         r192_in_ready, r192_out_valid, r192_out_last, r192_keyed, r192_wrap_err;
    logic [127:0] r192_out_data;
    logic [15:0]  r192_out_keep;
    logic         r256_in_ready, r256_out_valid, r256_out_last, r256_keyed, r256_wrap_err;
    logic [127:0] r256_out_data;
    logic [15:0]  r256_out_keep;

    always #5 clk = ~clk;

    aes_ctr_stream #(.KEY_LEN(128), .ROUNDS(10), .NK(4), .CTR_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
        .out_last(out_last), .keyed(keyed), .wrap_err(wrap_err));

    aes_ctr_stream #(.KEY_LEN(192), .ROUNDS(12), .NK(6), .CTR_W(32)) u_dut192 (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_key(key192), .cfg_iv(cfg_iv),
        .in_valid(in_valid), .in_ready(r192_in_ready), .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .out_valid(r192_out_valid), .out_ready(out_ready), .out_data(r192_out_data), .out_keep(r192_out_keep),
        .out_last(r192_out_last), .keyed(r192_keyed), .wrap_err(r192_wrap_err));

    aes_ctr_stream #(.KEY_LEN(256), .ROUNDS(14), .NK(8), .CTR_W(32)) u_dut256 (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_key(key256), .cfg_iv(cfg_iv),
        .in_valid(in_valid), .in_ready(r256_in_ready), .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .out_valid(r256_out_valid), .out_ready(out_ready), .out_data(r256_out_data), .out_keep(r256_out_keep),
        .out_last(r256_out_last), .keyed(r256_keyed), .wrap_err(r256_wrap_err));

    typedef struct {
        logic [127:0] key;
        logic [127:0] iv;
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
        logic [127:0] exp_data;
    } kat_t;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
    } exp_t;

    exp_t         sb_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [7:0]   sb [256];
    logic [127:0] model_key, model_ctr;
    logic [1:0]   ready_mode = 2'd1;
    logic         rnd_bit = 1'b0;

    // ready_mode: 0 hold low, 1 hold high, 2 pseudo-random per cycle
    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end
    assign out_ready = (ready_mode == 2'd2) ? rnd_bit : ready_mode[0];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box table generated by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc, a0, a1, a2, a3, tt;
        logic [127:0] s, ns;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sb[t[23:16]] ^ rc, sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    ns[127-8*(rr+4*c) -: 8] = sb[s[127-8*(rr+4*((c+rr)%4)) -: 8]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = ns[127-32*c -: 8];
                    a1 = ns[119-32*c -: 8];
                    a2 = ns[111-32*c -: 8];
                    a3 = ns[103-32*c -: 8];
                    tt = a0 ^ a1 ^ a2 ^ a3;
                    ns[127-32*c -: 32] = {a0 ^ tt ^ xt(a0 ^ a1), a1 ^ tt ^ xt(a1 ^ a2),
                                          a2 ^ tt ^ xt(a2 ^ a3), a3 ^ tt ^ xt(a3 ^ a0)};
                end
            end
            s = ns ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return s;
    endfunction

    function automatic logic [127:0] byte_mask(input logic [15:0] keep);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) if (keep[i]) m[8*i +: 8] = 8'hff;
        return m;
    endfunction

    task automatic do_load(input logic [127:0] key, input logic [127:0] iv);
        cfg_key  = key;
        cfg_iv   = iv;
        cfg_load = 1'b1;
        @(posedge clk);
        #1;
        cfg_load  = 1'b0;
        model_key = key;
        model_ctr = iv;
    endtask

    task automatic send_block(input logic [127:0] data, input logic [15:0] keep, input logic last,
                              input logic use_model, input logic [127:0] kat_exp);
        exp_t e;
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = data;
        in_keep  = keep;
        in_last  = last;
        for (int cyc = 0; cyc < 200 && !ok; cyc++) begin
            @(negedge clk);
            if (in_ready) begin
                e.data = use_model ? ((data ^ aes_model(model_key, model_ctr)) & byte_mask(keep)) : kat_exp;
                e.keep = keep;
                e.last = last;
                sb_q.push_back(e);
                model_ctr[31:0] = model_ctr[31:0] + 32'd1;
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("accept_timeout", ok, 1);
    endtask

    task automatic drain();
        for (int cyc = 0; cyc < 300 && (sb_q.size() != 0 || out_valid); cyc++) @(negedge clk);
        check("drain_empty", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on every handshake and checks hold-stability on stalls.
    logic [127:0] held_data;
    logic [15:0]  held_keep;
    logic         held_last;
    logic         stalled_prev = 1'b0;
    exp_t         got_e;
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (stalled_prev) begin
                check("stall_data_stable", out_data, held_data);
                check("stall_keep_stable", {out_keep, out_last}, {held_keep, held_last});
            end
            if (out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    got_e = sb_q.pop_front();
                    check("out_data", out_data, got_e.data);
                    check("out_keep", out_keep, got_e.keep);
                    check("out_last", out_last, got_e.last);
                end
            end
            stalled_prev = !out_ready;
            held_data    = out_data;
            held_keep    = out_keep;
            held_last    = out_last;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] IV1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] E1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    kat_t kat [7];

    initial begin
        kat[0] = '{K1, IV1, 128'h0, 16'hffff, 1'b0, E1};
        kat[1] = '{K1, IV1, E1, 16'hffff, 1'b1, 128'h0};
        kat[2] = '{K1, IV1, 128'h0, 16'hff00, 1'b1, {E1[127:64], 64'h0}};
        kat[3] = '{K2, 128'h3243f6a8885a308d313198a2e0370734, 128'h0, 16'hffff, 1'b0,
                   128'h3925841d02dc09fbdc118597196a0b32};
        kat[4] = '{K1, IV1, {128{1'b1}}, 16'h0000, 1'b0, 128'h0};
        kat[5] = '{K1, IV1, {128{1'b1}}, 16'h00ff, 1'b1, {64'h0, 64'h2732487f8f4b3aa5}};
        kat[6] = '{K2, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 128'h6bc1bee22e409f96e93d7e117393172a,
                   16'hffff, 1'b0, 128'h874d6191b620e3261bef6864990db6ce};

        build_sbox();
        key192     = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
        key256     = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        rst_n      = 1'b0;
        cfg_load   = 1'b0;
        cfg_key    = '0;
        cfg_iv     = '0;
        in_valid   = 1'b1;
        in_data    = '0;
        in_keep    = 16'hffff;
        in_last    = 1'b0;
        model_key  = '0;
        model_ctr  = '0;
        ready_mode = 2'd1;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_keep", out_keep, 0);
        check("rst_out_last", out_last, 0);
        check("rst_keyed", keyed, 0);
        check("rst_wrap_err", wrap_err, 0);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // 192/256-bit instances alongside the 128-bit one, then a model-checked follow-on block.
        do_load(K1, IV1);
        send_block(128'h0, 16'hffff, 1'b0, 1'b0, E1);
        @(negedge clk);
        check("aes192_out", r192_out_data, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        check("aes256_out", r256_out_data, 128'h8ea2b7ca516745bfeafc49904b496089);
        check("keyed_after_load", keyed, 1);
        @(posedge clk);
        #1;
        send_block({$urandom, $urandom, $urandom, $urandom}, 16'hffff, 1'b0, 1'b1, '0);
        drain();

        for (int i = 0; i < 7; i++) begin
            do_load(kat[i].key, kat[i].iv);
            send_block(kat[i].data, kat[i].keep, kat[i].last, 1'b0, kat[i].exp_data);
            drain();
        end

        do_load(K2, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
        ready_mode = 2'd2;
        for (int i = 0; i < 8; i++)
            send_block({$urandom, $urandom, $urandom, $urandom}, 16'hffff, (i == 7), 1'b1, '0);
        drain();
        ready_mode = 2'd1;

        // Counter wrap: all-ones block goes through, then the unit halts.
        do_load(K1, {96'h0123456789abcdef01234567, 32'hffffffff});
        send_block(128'hdeadbeef_00000000_cafef00d_12345678, 16'hffff, 1'b1, 1'b1, '0);
        in_valid = 1'b1;
        @(negedge clk);
        check("wrap_err_set", wrap_err, 1);
        check("wrap_in_ready", in_ready, 0);
        check("wrap_keyed", keyed, 1);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("halt_no_output", out_valid, 0);
            check("halt_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        do_load(K1, IV1);
        @(negedge clk);
        check("reload_wrap_err", wrap_err, 0);
        check("reload_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        send_block(128'h0, 16'hffff, 1'b0, 1'b1, '0);
        drain();

        // Reload while an output is stalled, with a block offered in the load cycle.
        ready_mode = 2'd0;
        send_block(128'h5555, 16'hffff, 1'b0, 1'b1, '0);
        repeat (2) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        cfg_key  = K2;
        cfg_iv   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
        cfg_load = 1'b1;
        in_valid = 1'b1;
        in_data  = 128'h6bc1bee22e409f96e93d7e117393172a;
        in_keep  = 16'hffff;
        @(negedge clk);
        check("load_cycle_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        cfg_load  = 1'b0;
        in_valid  = 1'b0;
        model_key = K2;
        model_ctr = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
        sb_q.delete();
        @(negedge clk);
        check("load_discard_valid", out_valid, 0);
        check("load_then_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        ready_mode = 2'd1;
        send_block(128'h6bc1bee22e409f96e93d7e117393172a, 16'hffff, 1'b0, 1'b0,
                   128'h874d6191b620e3261bef6864990db6ce);
        drain();

        // Reset while an output is stalled.
        ready_mode = 2'd0;
        send_block(128'h1234, 16'h0f0f, 1'b1, 1'b1, '0);
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_keep", out_keep, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_keyed", keyed, 0);
        check("mid_rst_wrap_err", wrap_err, 0);
        check("mid_rst_in_ready", in_ready, 0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        ready_mode = 2'd1;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
